v_wb_sched: RTL and testbench

- Writeback scheduler and hazard scoreboard for the 32-entry vector register file.
- Shares the single regfile write port between the vector ALU and the vector load/store unit using round-robin arbitration, and drives the write port from a register stage.
- Tracks pending destination writes per vector register and stalls vector issue on RAW/WAW hazards.
- Sits between vector decode/issue, the two execution units, and the regfile write port.

---
 rtl/v_wb_sched.sv | 124 ++++++++++++
 tb/tb_v_wb_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_wb_sched.sv
// Vector writeback scheduler and hazard scoreboard.
// Two execution units (ALU, LSU) share the single vector regfile write port
// through a round-robin arbiter; the granted request is registered onto the
// write port. A 32-bit scoreboard tracks destination registers with pending
// writes and holds back issue on RAW/WAW hazards.
//
// Handshake: a requester (issue, ALU, LSU) holds vld and its payload stable
// until the matching rdy is high in the same cycle; vld & rdy at a rising
// edge is a transfer. rdy never depends on the requester's own payload
// changing within the cycle.
module v_wb_sched #(
  parameter int VREG_W  = 256,
  parameter int VADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_vld_i,
  input  logic               issue_wen_i,
  input  logic [VADDR_W-1:0] issue_vd_i,
  input  logic               issue_vs1_en_i,
  input  logic [VADDR_W-1:0] issue_vs1_i,
  input  logic               issue_vs2_en_i,
  input  logic [VADDR_W-1:0] issue_vs2_i,
  output logic               issue_rdy_o,
  input  logic               alu_vld_i,
  input  logic [VADDR_W-1:0] alu_addr_i,
  input  logic [VREG_W-1:0]  alu_data_i,
  output logic               alu_rdy_o,
  input  logic               lsu_vld_i,
  input  logic [VADDR_W-1:0] lsu_addr_i,
  input  logic [VREG_W-1:0]  lsu_data_i,
  output logic               lsu_rdy_o,
  output logic               vwb_en_o,
  output logic [VADDR_W-1:0] vwb_addr_o,
  output logic [VREG_W-1:0]  vwb_data_o,
  output logic [31:0]        busy_o,
  output logic               err_o
);

  // Round-robin pointer: names the requester that wins the next contention.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_t;

  rr_t                rr_q, rr_d;
  logic [31:0]        busy_q, busy_d;
  logic               err_q, err_d;
  logic               alu_gnt, lsu_gnt, any_gnt;
  logic [VADDR_W-1:0] gnt_addr;
  logic [VREG_W-1:0]  gnt_data;
  logic               issue_fire;
  logic               gnt_clr;

  // Hazard check uses registered busy only; a clear landing this cycle is
  // not bypassed, so the instruction waits one extra cycle.
  always_comb begin
    issue_rdy_o = !(issue_vs1_en_i && busy_q[issue_vs1_i]) &&
                  !(issue_vs2_en_i && busy_q[issue_vs2_i]) &&
                  !(issue_wen_i    && busy_q[issue_vd_i]);
    issue_fire  = issue_vld_i && issue_rdy_o && issue_wen_i &&
                  (issue_vd_i != '0);
  end

  // Arbiter: uncontended requests win outright; contention goes to the
  // pointer. The pointer then names whoever did not win.
  always_comb begin
    alu_gnt = alu_vld_i && (!lsu_vld_i || (rr_q == RR_ALU));
    lsu_gnt = lsu_vld_i && (!alu_vld_i || (rr_q == RR_LSU));
    any_gnt = alu_gnt || lsu_gnt;
    rr_d    = rr_q;
    if (alu_gnt)      rr_d = RR_LSU;
    else if (lsu_gnt) rr_d = RR_ALU;
    gnt_addr = alu_gnt ? alu_addr_i : lsu_addr_i;
    gnt_data = alu_gnt ? alu_data_i : lsu_data_i;
    alu_rdy_o = alu_gnt;
    lsu_rdy_o = lsu_gnt;
  end

  // Scoreboard and error next state. v0 is never tracked; set and clear of
  // the same index cannot coincide because issue is blocked while busy.
  always_comb begin
    gnt_clr = any_gnt && (gnt_addr != '0);
    busy_d  = busy_q;
    err_d   = err_q;
    if (issue_fire) busy_d[issue_vd_i] = 1'b1;
    if (gnt_clr) begin
      busy_d[gnt_addr] = 1'b0;
      if (!busy_q[gnt_addr]) err_d = 1'b1;
    end
  end

  // State registers: pointer, scoreboard, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= RR_ALU;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Write port stage: one-cycle latency; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vwb_en_o   <= 1'b0;
      vwb_addr_o <= '0;
      vwb_data_o <= '0;
    end else begin
      vwb_en_o <= any_gnt;
      if (any_gnt) begin
        vwb_addr_o <= gnt_addr;
        vwb_data_o <= gnt_data;
      end
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_v_wb_sched.sv
// Directed testbench for v_wb_sched. Inputs change on the falling edge;
// combinational outputs are sampled 1ns later, registered outputs 1ns after
// the rising edge.
module tb_v_wb_sched;

  localparam int VREG_W  = 256;
  localparam int VADDR_W = 5;

  logic               clk;
  logic               rst_n;
  logic               issue_vld_i, issue_wen_i;
  logic [VADDR_W-1:0] issue_vd_i, issue_vs1_i, issue_vs2_i;
  logic               issue_vs1_en_i, issue_vs2_en_i;
  logic               issue_rdy_o;
  logic               alu_vld_i, lsu_vld_i;
  logic [VADDR_W-1:0] alu_addr_i, lsu_addr_i;
  logic [VREG_W-1:0]  alu_data_i, lsu_data_i;
  logic               alu_rdy_o, lsu_rdy_o;
  logic               vwb_en_o;
  logic [VADDR_W-1:0] vwb_addr_o;
  logic [VREG_W-1:0]  vwb_data_o;
  logic [31:0]        busy_o;
  logic               err_o;

  int checks = 0;
  int errors = 0;

  v_wb_sched #(.VREG_W(VREG_W), .VADDR_W(VADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_vld_i(issue_vld_i), .issue_wen_i(issue_wen_i),
    .issue_vd_i(issue_vd_i),
    .issue_vs1_en_i(issue_vs1_en_i), .issue_vs1_i(issue_vs1_i),
    .issue_vs2_en_i(issue_vs2_en_i), .issue_vs2_i(issue_vs2_i),
    .issue_rdy_o(issue_rdy_o),
    .alu_vld_i(alu_vld_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .alu_rdy_o(alu_rdy_o),
    .lsu_vld_i(lsu_vld_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_rdy_o(lsu_rdy_o),
    .vwb_en_o(vwb_en_o), .vwb_addr_o(vwb_addr_o), .vwb_data_o(vwb_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    issue_vld_i = 0; issue_wen_i = 0; issue_vd_i = 0;
    issue_vs1_en_i = 0; issue_vs1_i = 0; issue_vs2_en_i = 0; issue_vs2_i = 0;
    alu_vld_i = 0; alu_addr_i = 0; alu_data_i = '0;
    lsu_vld_i = 0; lsu_addr_i = 0; lsu_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Issue one writing instruction with no source operands; returns on the
  // falling edge after the firing rising edge, with issue_vld_i low.
  task automatic issue_one(input logic [VADDR_W-1:0] vd);
    @(negedge clk);
    issue_vld_i = 1; issue_wen_i = 1; issue_vd_i = vd;
    issue_vs1_en_i = 0; issue_vs2_en_i = 0;
    @(posedge clk);
    @(negedge clk);
    issue_vld_i = 0; issue_wen_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy_o, 32'h0); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++; if (vwb_en_o !== 1'b0) begin errors++; $display("FAIL reset_vwb_en got %b exp 0", vwb_en_o); end
    checks++; if (vwb_addr_o !== 5'd0) begin errors++; $display("FAIL reset_vwb_addr got %0d exp 0", vwb_addr_o); end
    checks++; if (vwb_data_o !== '0) begin errors++; $display("FAIL reset_vwb_data got %h exp 0", vwb_data_o); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_issue();
    @(negedge clk);
    issue_vld_i = 1; issue_wen_i = 1; issue_vd_i = 5;
    issue_vs1_en_i = 1; issue_vs1_i = 2; issue_vs2_en_i = 1; issue_vs2_i = 3;
    #1;
    checks++; if (issue_rdy_o !== 1'b1) begin errors++; $display("FAIL issue_rdy got %b exp 1", issue_rdy_o); end
    @(posedge clk); #1;
    checks++; if (busy_o !== 32'h0000_0020) begin errors++; $display("FAIL issue_busy got %h exp %h", busy_o, 32'h20); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_hazard();
    @(negedge clk);
    issue_vs1_en_i = 1; issue_vs1_i = 5;
    #1;
    checks++; if (issue_rdy_o !== 1'b0) begin errors++; $display("FAIL raw_vs1 got %b exp 0", issue_rdy_o); end
    issue_vs1_en_i = 0;
    #1;
    checks++; if (issue_rdy_o !== 1'b1) begin errors++; $display("FAIL raw_vs1_disabled got %b exp 1", issue_rdy_o); end
    issue_vs2_en_i = 1; issue_vs2_i = 5;
    #1;
    checks++; if (issue_rdy_o !== 1'b0) begin errors++; $display("FAIL raw_vs2 got %b exp 0", issue_rdy_o); end
    issue_vs2_en_i = 0; issue_wen_i = 1; issue_vd_i = 5;
    #1;
    checks++; if (issue_rdy_o !== 1'b0) begin errors++; $display("FAIL waw_vd got %b exp 0", issue_rdy_o); end
    clear_inputs();
  endtask

  task automatic test_alu_wb();
    logic [VREG_W-1:0] d;
    d = {32{8'hA5}};
    @(negedge clk);
    alu_vld_i = 1; alu_addr_i = 5; alu_data_i = d;
    #1;
    checks++; if (alu_rdy_o !== 1'b1) begin errors++; $display("FAIL alu_rdy got %b exp 1", alu_rdy_o); end
    checks++; if (lsu_rdy_o !== 1'b0) begin errors++; $display("FAIL alu_only_lsu_rdy got %b exp 0", lsu_rdy_o); end
    @(posedge clk); #1;
    checks++; if (vwb_en_o !== 1'b1) begin errors++; $display("FAIL alu_wb_en got %b exp 1", vwb_en_o); end
    checks++; if (vwb_addr_o !== 5'd5) begin errors++; $display("FAIL alu_wb_addr got %0d exp 5", vwb_addr_o); end
    checks++; if (vwb_data_o !== d) begin errors++; $display("FAIL alu_wb_data got %h exp %h", vwb_data_o, d); end
    checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL alu_wb_busy got %h exp 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL alu_wb_err got %b exp 0", err_o); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    checks++; if (vwb_en_o !== 1'b0) begin errors++; $display("FAIL idle_wb_en got %b exp 0", vwb_en_o); end
    checks++; if (vwb_addr_o !== 5'd5) begin errors++; $display("FAIL idle_wb_addr_hold got %0d exp 5", vwb_addr_o); end
    checks++; if (vwb_data_o !== d) begin errors++; $display("FAIL idle_wb_data_hold got %h exp %h", vwb_data_o, d); end
  endtask

  task automatic test_back_to_back();
    logic [VREG_W-1:0] dx, dy, dz;
    dx = {32{8'h44}}; dy = {32{8'h66}}; dz = {8{32'h1234_5678}};
    do_reset();
    issue_one(4);
    issue_one(6);
    checks++; if (busy_o !== 32'h0000_0050) begin errors++; $display("FAIL b2b_busy_set got %h exp %h", busy_o, 32'h50); end
    // Both valid with pointer at ALU.
    alu_vld_i = 1; alu_addr_i = 4; alu_data_i = dx;
    lsu_vld_i = 1; lsu_addr_i = 6; lsu_data_i = dy;
    #1;
    checks++; if ({alu_rdy_o, lsu_rdy_o} !== 2'b10) begin errors++; $display("FAIL b2b_gnt1 got %b exp 10", {alu_rdy_o, lsu_rdy_o}); end
    @(posedge clk); #1;
    checks++; if (vwb_addr_o !== 5'd4 || vwb_en_o !== 1'b1) begin errors++; $display("FAIL b2b_wb1 got en %b addr %0d exp en 1 addr 4", vwb_en_o, vwb_addr_o); end
    checks++; if (vwb_data_o !== dx) begin errors++; $display("FAIL b2b_wb1_data got %h exp %h", vwb_data_o, dx); end
    checks++; if (busy_o !== 32'h0000_0040) begin errors++; $display("FAIL b2b_busy1 got %h exp %h", busy_o, 32'h40); end
    // ALU presents a new request to v0; contention now goes to LSU.
    @(negedge clk);
    alu_addr_i = 0; alu_data_i = dz;
    #1;
    checks++; if ({alu_rdy_o, lsu_rdy_o} !== 2'b01) begin errors++; $display("FAIL b2b_gnt2 got %b exp 01", {alu_rdy_o, lsu_rdy_o}); end
    @(posedge clk); #1;
    checks++; if (vwb_addr_o !== 5'd6 || vwb_en_o !== 1'b1) begin errors++; $display("FAIL b2b_wb2 got en %b addr %0d exp en 1 addr 6", vwb_en_o, vwb_addr_o); end
    checks++; if (vwb_data_o !== dy) begin errors++; $display("FAIL b2b_wb2_data got %h exp %h", vwb_data_o, dy); end
    checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL b2b_busy2 got %h exp 0", busy_o); end
    @(negedge clk);
    lsu_vld_i = 0;
    #1;
    checks++; if (alu_rdy_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt3 got %b exp 1", alu_rdy_o); end
    @(posedge clk); #1;
    checks++; if (vwb_en_o !== 1'b1 || vwb_addr_o !== 5'd0) begin errors++; $display("FAIL v0_wb got en %b addr %0d exp en 1 addr 0", vwb_en_o, vwb_addr_o); end
    checks++; if (vwb_data_o !== dz) begin errors++; $display("FAIL v0_wb_data got %h exp %h", vwb_data_o, dz); end
    checks++; if (err_o !== 1'b0 || busy_o !== 32'h0) begin errors++; $display("FAIL v0_side_effects got err %b busy %h exp err 0 busy 0", err_o, busy_o); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_err();
    logic [VREG_W-1:0] d;
    d = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    lsu_vld_i = 1; lsu_addr_i = 9; lsu_data_i = d;
    #1;
    checks++; if (lsu_rdy_o !== 1'b1) begin errors++; $display("FAIL err_lsu_rdy got %b exp 1", lsu_rdy_o); end
    @(posedge clk); #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_o); end
    checks++; if (vwb_en_o !== 1'b1 || vwb_addr_o !== 5'd9) begin errors++; $display("FAIL err_fwd got en %b addr %0d exp en 1 addr 9", vwb_en_o, vwb_addr_o); end
    checks++; if (vwb_data_o !== d) begin errors++; $display("FAIL err_fwd_data got %h exp %h", vwb_data_o, d); end
    @(negedge clk);
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
  endtask

  task automatic test_async_reset();
    issue_one(4);
    // Issue v5 while an ALU write to v0 is granted: busy becomes 0x30 with
    // the write port active and the error still latched.
    @(negedge clk);
    issue_vld_i = 1; issue_wen_i = 1; issue_vd_i = 5;
    alu_vld_i = 1; alu_addr_i = 0; alu_data_i = {32{8'h3C}};
    @(posedge clk); #1;
    checks++; if (busy_o !== 32'h0000_0030) begin errors++; $display("FAIL pre_rst_busy got %h exp %h", busy_o, 32'h30); end
    checks++; if (vwb_en_o !== 1'b1 || err_o !== 1'b1) begin errors++; $display("FAIL pre_rst_state got en %b err %b exp en 1 err 1", vwb_en_o, err_o); end
    issue_vld_i = 0;
    #2;
    rst_n = 0;
    #1;
    checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL async_rst_busy got %h exp 0", busy_o); end
    checks++; if (vwb_en_o !== 1'b0) begin errors++; $display("FAIL async_rst_vwb_en got %b exp 0", vwb_en_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL async_rst_err got %b exp 0", err_o); end
    checks++; if (vwb_addr_o !== 5'd0 || vwb_data_o !== '0) begin errors++; $display("FAIL async_rst_vwb_payload got addr %0d data %h exp 0", vwb_addr_o, vwb_data_o); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    // Pointer must be back at ALU after reset.
    alu_vld_i = 1; alu_addr_i = 1; lsu_vld_i = 1; lsu_addr_i = 2;
    #1;
    checks++; if ({alu_rdy_o, lsu_rdy_o} !== 2'b10) begin errors++; $display("FAIL rst_pointer got %b exp 10", {alu_rdy_o, lsu_rdy_o}); end
    clear_inputs();
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_issue();
    test_hazard();
    test_alu_wb();
    test_back_to_back();
    test_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
